// File: rtl/pac_pkg.sv
// rtl/pac_pkg.sv - shared types, keycodes and grid constants for pacman_motion
package pac_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT,
        DIR_LEFT,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_AHEAD,
        ST_STEP
    } state_t;

    // Pending turn request: valid flag plus heading.
    typedef struct packed {
        logic valid;
        dir_t dir;
    } req_t;

    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;

    localparam int GRID_COLS  = 28;
    localparam int GRID_ROWS  = 29;
    localparam int TILE_SHIFT = 4;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_RIGHT: opposite = DIR_LEFT;
            DIR_LEFT:  opposite = DIR_RIGHT;
            DIR_UP:    opposite = DIR_DOWN;
            default:   opposite = DIR_UP;
        endcase
    endfunction

    function automatic req_t keycode_to_dir(input logic [7:0] kc);
        keycode_to_dir = '0;
        case (kc)
            KEY_RIGHT: keycode_to_dir = '{valid: 1'b1, dir: DIR_RIGHT};
            KEY_LEFT:  keycode_to_dir = '{valid: 1'b1, dir: DIR_LEFT};
            KEY_UP:    keycode_to_dir = '{valid: 1'b1, dir: DIR_UP};
            KEY_DOWN:  keycode_to_dir = '{valid: 1'b1, dir: DIR_DOWN};
            default:   keycode_to_dir = '0;
        endcase
    endfunction

endpackage

// File: rtl/pacman_motion.sv
// rtl/pacman_motion.sv - per-frame player motion with tile-by-tile wall probing
//
// Ports:
//   clock, Reset_n        - clock, asynchronous active-low reset
//   frame_tick            - one-cycle frame strobe (ignored while busy)
//   keycode[7:0]          - current key; D/A/W/S request right/left/up/down
//   query_tx/ty[4:0]      - tile being probed in the wall ROM (current tile when idle)
//   query_wall            - combinational wall bit for the queried tile
//   PacmanX/PacmanY[9:0]  - top-left pixel position of the player
//   pac_dir               - current heading
//   moving                - last frame advanced the position
//   busy                  - frame sequence in progress
module pacman_motion
    import pac_pkg::*;
#(
    parameter int SPEED    = 2,
    parameter int START_TX = 13,
    parameter int START_TY = 22
) (
    input  logic       clock,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic [4:0] query_tx,
    output logic [4:0] query_ty,
    input  logic       query_wall,
    output logic [9:0] PacmanX,
    output logic [9:0] PacmanY,
    output dir_t       pac_dir,
    output logic       moving,
    output logic       busy
);

    localparam logic [9:0] RESET_X  = 10'(START_TX << TILE_SHIFT);
    localparam logic [9:0] RESET_Y  = 10'(START_TY << TILE_SHIFT);
    localparam logic [9:0] STEP_PX  = 10'(SPEED);
    localparam logic [4:0] COL_LAST = 5'(GRID_COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(GRID_ROWS - 1);

    state_t     state, state_nx;
    req_t       req, req_nx, key_req, eff_req;
    dir_t       dir, dir_nx, probe_dir;
    logic [9:0] pos_x, pos_y, x_nx, y_nx;
    logic       mov, mov_nx;

    logic [4:0] cur_tx, cur_ty, nb_tx, nb_ty;
    logic       nb_out, aligned, turn_probe, ahead_probe, probing, blocked;

    assign key_req = keycode_to_dir(keycode);
    // A key pressed during TURN must steer that very probe, so it bypasses req.
    assign eff_req = key_req.valid ? key_req : req;
    assign aligned = (pos_x[3:0] == 4'd0) && (pos_y[3:0] == 4'd0);
    assign cur_tx  = pos_x[8:4];
    assign cur_ty  = pos_y[8:4];

    // Neighbour tile in the direction under test; grid edges count as walls.
    always_comb begin
        probe_dir = (state == ST_TURN) ? eff_req.dir : dir;
        nb_tx     = cur_tx;
        nb_ty     = cur_ty;
        nb_out    = 1'b0;
        case (probe_dir)
            DIR_RIGHT: if (cur_tx == COL_LAST) nb_out = 1'b1; else nb_tx = cur_tx + 5'd1;
            DIR_LEFT:  if (cur_tx == 5'd0)     nb_out = 1'b1; else nb_tx = cur_tx - 5'd1;
            DIR_UP:    if (cur_ty == 5'd0)     nb_out = 1'b1; else nb_ty = cur_ty - 5'd1;
            default:   if (cur_ty == ROW_LAST) nb_out = 1'b1; else nb_ty = cur_ty + 5'd1;
        endcase
    end

    assign turn_probe  = (state == ST_TURN) && eff_req.valid &&
                         (eff_req.dir != opposite(dir)) && aligned;
    assign ahead_probe = (state == ST_AHEAD) && aligned;
    assign probing     = (turn_probe || ahead_probe) && !nb_out;
    assign query_tx    = probing ? nb_tx : cur_tx;
    assign query_ty    = probing ? nb_ty : cur_ty;
    assign blocked     = nb_out || query_wall;

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        mov_nx   = mov;
        x_nx     = pos_x;
        y_nx     = pos_y;
        req_nx   = key_req.valid ? key_req : req;
        case (state)
            ST_IDLE: begin
                if (frame_tick) state_nx = ST_TURN;
            end
            ST_TURN: begin
                state_nx = ST_AHEAD;
                if (eff_req.valid && (eff_req.dir == opposite(dir))) begin
                    // Reversal never needs a probe: the tile behind is where we came from.
                    dir_nx = eff_req.dir;
                    req_nx = '0;
                end else if (eff_req.valid && aligned && !blocked) begin
                    dir_nx = eff_req.dir;
                    req_nx = '0;
                end
            end
            ST_AHEAD: begin
                if (aligned && blocked) begin
                    mov_nx   = 1'b0;
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_STEP;
                end
            end
            default: begin
                case (dir)
                    DIR_RIGHT: x_nx = pos_x + STEP_PX;
                    DIR_LEFT:  x_nx = pos_x - STEP_PX;
                    DIR_UP:    y_nx = pos_y - STEP_PX;
                    default:   y_nx = pos_y + STEP_PX;
                endcase
                mov_nx   = 1'b1;
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
            req   <= '0;
            dir   <= DIR_LEFT;
            pos_x <= RESET_X;
            pos_y <= RESET_Y;
            mov   <= 1'b0;
        end else begin
            state <= state_nx;
            req   <= req_nx;
            dir   <= dir_nx;
            pos_x <= x_nx;
            pos_y <= y_nx;
            mov   <= mov_nx;
        end
    end

    assign PacmanX = pos_x;
    assign PacmanY = pos_y;
    assign pac_dir = dir;
    assign moving  = mov;
    assign busy    = (state != ST_IDLE);

endmodule
